// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: defaults, FSM encoding, vector helper.
package intr_ctrl_pkg;

  localparam int          INTC_NUM_IRQ    = 2;
  localparam int          INTC_PC_W       = 10;
  localparam int unsigned INTC_VEC_BASE   = 32'h3F0;
  localparam int unsigned INTC_VEC_STRIDE = 4;

  // Cycles after reset before an edge detector may fire; a level already
  // present on a line when reset is released is taken as the baseline.
  localparam int SYNC_ARM_CYC = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } intc_state_e;

  function automatic int unsigned vec_addr(input int unsigned base,
                                           input int unsigned stride,
                                           input int unsigned idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/intr_sync_edge.sv
// One interrupt line: 2-FF synchroniser followed by a rising-edge detector.
module intr_sync_edge
  import intr_ctrl_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_line,
  output logic o_evt
);

  logic                    r_meta;
  logic                    r_sync;
  logic                    r_sync_d;
  logic [SYNC_ARM_CYC-1:0] r_arm;

  // Synchronise the raw line, keep one delayed copy and fill the arming shift register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
      r_arm    <= '0;
    end else begin
      r_meta   <= i_line;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
      r_arm    <= {r_arm[SYNC_ARM_CYC-2:0], 1'b1};
    end
  end

  // Single-cycle event per rising edge, suppressed until the chain has settled after reset.
  assign o_evt = r_sync & ~r_sync_d & r_arm[SYNC_ARM_CYC-1];

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: per-line edge capture, pending/mask registers,
// fixed-priority select (index 0 highest) and a non-nesting request FSM.
//
//   state | meaning
//   IDLE  | no request outstanding; waits for an eligible pending source
//   REQ   | irq asserted, vector/irq_id frozen until ack or source masked
//   SVC   | ISR running; new events only accumulate until reti
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int          NUM_IRQ    = INTC_NUM_IRQ,
  parameter int          PC_W       = INTC_PC_W,
  parameter int unsigned VEC_BASE   = INTC_VEC_BASE,
  parameter int unsigned VEC_STRIDE = INTC_VEC_STRIDE
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_IRQ-1:0] i_intr,
  input  logic               i_mask_we,
  input  logic [NUM_IRQ-1:0] i_mask_din,
  input  logic               i_ack,
  input  logic               i_reti,
  output logic               o_irq,
  output logic [PC_W-1:0]    o_vector,
  output logic [NUM_IRQ-1:0] o_irq_id,
  output logic [NUM_IRQ-1:0] o_pending_q,
  output logic [NUM_IRQ-1:0] o_mask_q
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  intc_state_e        r_state;
  intc_state_e        w_state_nxt;
  logic [NUM_IRQ-1:0] w_evt;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] w_elig;
  logic [NUM_IRQ-1:0] w_sel;
  logic [IDX_W-1:0]   w_idx;
  logic [PC_W-1:0]    w_vec;
  logic [PC_W-1:0]    r_vector;
  logic [NUM_IRQ-1:0] r_irq_id;
  logic [NUM_IRQ-1:0] w_clr;
  logic               w_irq;
  logic               w_take;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
    intr_sync_edge u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_line  (i_intr[g]),
      .o_evt   (w_evt[g])
    );
  end

  assign w_elig = r_pending & r_mask;
  // Isolate the lowest set bit: that is the winning source as a one-hot id.
  assign w_sel  = w_elig & (~w_elig + NUM_IRQ'(1));

  // Binary index of the winning source; scanning downward leaves the lowest index.
  always_comb begin
    w_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) w_idx = IDX_W'(i);
    end
  end

  assign w_vec = PC_W'(vec_addr(VEC_BASE, VEC_STRIDE, 32'(w_idx)));

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state logic; ack only counts in REQ, reti only in SVC.
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: w_state_nxt = (|w_elig) ? ST_REQ : ST_IDLE;
      ST_REQ: begin
        if (i_ack)                       w_state_nxt = ST_SVC;
        else if (~|(r_irq_id & r_mask))  w_state_nxt = ST_IDLE;
        else                             w_state_nxt = ST_REQ;
      end
      ST_SVC:  w_state_nxt = i_reti ? ST_IDLE : ST_SVC;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: request level, pending clear on ack, and capture strobe in IDLE.
  always_comb begin
    w_irq  = (r_state == ST_REQ);
    w_clr  = (r_state == ST_REQ && i_ack) ? r_irq_id : '0;
    w_take = (r_state == ST_IDLE) && (|w_elig);
  end

  // Latch id/vector when a request is taken; drop the id whenever the FSM returns to IDLE.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_vector <= '0;
      r_irq_id <= '0;
    end else if (w_take) begin
      r_vector <= w_vec;
      r_irq_id <= w_sel;
    end else if (w_state_nxt == ST_IDLE && r_state != ST_IDLE) begin
      r_irq_id <= '0;
    end
  end

  // Pending and mask registers; a new event beats a same-cycle ack clear.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_evt;
      if (i_mask_we) r_mask <= i_mask_din;
    end
  end

  assign o_irq       = w_irq;
  assign o_vector    = r_vector;
  assign o_irq_id    = r_irq_id;
  assign o_pending_q = r_pending;
  assign o_mask_q    = r_mask;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] intr = 2'b00;
  logic       mask_we = 1'b0;
  logic [1:0] mask_din = 2'b00;
  logic       ack = 1'b0;
  logic       reti = 1'b0;

  logic       o_irq;
  logic [9:0] o_vector;
  logic [1:0] o_irq_id;
  logic [1:0] o_pending_q;
  logic [1:0] o_mask_q;

  intr_ctrl dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_intr      (intr),
    .i_mask_we   (mask_we),
    .i_mask_din  (mask_din),
    .i_ack       (ack),
    .i_reti      (reti),
    .o_irq       (o_irq),
    .o_vector    (o_vector),
    .o_irq_id    (o_irq_id),
    .o_pending_q (o_pending_q),
    .o_mask_q    (o_mask_q)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: requesting / servicing flags and the visible registers.
  bit         m_req, m_svc;
  logic [1:0] m_pend, m_mask, m_id;
  logic [9:0] m_vec;
  int         n_edge;
  logic [1:0] hist [0:8191];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_svc = 0; m_pend = 0; m_mask = 0; m_id = 0; m_vec = 0; n_edge = 0;
  endtask

  // One rising clock edge of the model, using inputs as seen at that edge.
  task automatic model_edge();
    logic [1:0] evt, elig, clr;
    n_edge++;
    hist[n_edge] = intr;
    evt = 2'b00;
    // A sample taken at edge k shows up as pending at edge k+2; the sample at
    // the first edge after reset is only the baseline level.
    if (n_edge >= 4) evt = hist[n_edge-2] & ~hist[n_edge-3];
    elig = m_pend & m_mask;
    clr  = 2'b00;
    if (!m_req && !m_svc) begin
      if (elig != 0) begin
        for (int i = 1; i >= 0; i--) begin
          if (elig[i]) begin
            m_id  = 2'b00;
            m_id[i] = 1'b1;
            m_vec = 10'(32'h3F0 + 4 * i);
          end
        end
        m_req = 1;
      end
    end else if (m_req) begin
      if (ack) begin
        m_req = 0; m_svc = 1; clr = m_id;
      end else if ((m_id & m_mask) == 0) begin
        m_req = 0; m_id = 0;
      end
    end else begin
      if (reti) begin
        m_svc = 0; m_id = 0;
      end
    end
    m_pend = (m_pend & ~clr) | evt;
    if (mask_we) m_mask = mask_din;
  endtask

  task automatic check_all();
    chk("irq", 32'(o_irq), 32'(m_req));
    chk("vector", 32'(o_vector), 32'(m_vec));
    chk("irq_id", 32'(o_irq_id), 32'(m_id));
    chk("pending", 32'(o_pending_q), 32'(m_pend));
    chk("mask", 32'(o_mask_q), 32'(m_mask));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_mask(input logic [1:0] v);
    mask_we = 1; mask_din = v;
    tick();
    mask_we = 0;
  endtask

  task automatic pulse_ack();
    ack = 1; tick(); ack = 0;
  endtask

  task automatic pulse_reti();
    reti = 1; tick(); reti = 0;
  endtask

  // Reset asserted mid-cycle, held across one edge, then released.
  task automatic do_reset();
    rst_n = 0;
    model_reset();
    #1;
    check_all();
    tick();
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    #2;
    check_all();
    #20;
    rst_n = 1;
    ticks(6);

    // 1: single source, latency and ack
    write_mask(2'b11);
    intr = 2'b01;
    ticks(3);
    chk("t1_pend_e2", 32'(o_pending_q), 32'h1);
    chk("t1_irq_e2", 32'(o_irq), 32'h0);
    tick();
    chk("t1_irq_e3", 32'(o_irq), 32'h1);
    chk("t1_vec", 32'(o_vector), 32'h3F0);
    chk("t1_id", 32'(o_irq_id), 32'h1);
    tick();
    pulse_ack();
    chk("t1_irq_ack", 32'(o_irq), 32'h0);
    chk("t1_pend_ack", 32'(o_pending_q), 32'h0);
    pulse_reti();
    intr = 2'b00;
    ticks(3);

    // 2: simultaneous rise, priority then second request
    intr = 2'b11;
    ticks(4);
    chk("t2_vec0", 32'(o_vector), 32'h3F0);
    pulse_ack();
    pulse_reti();
    tick();
    chk("t2_irq2", 32'(o_irq), 32'h1);
    chk("t2_vec1", 32'(o_vector), 32'h3F4);
    chk("t2_id1", 32'(o_irq_id), 32'h2);
    pulse_ack();
    pulse_reti();
    intr = 2'b00;
    ticks(3);

    // 3: masked source latches pending, request appears after unmask
    write_mask(2'b10);
    intr = 2'b01;
    ticks(2);
    intr = 2'b00;
    ticks(3);
    chk("t3_pend", 32'(o_pending_q), 32'h1);
    chk("t3_irq_masked", 32'(o_irq), 32'h0);
    write_mask(2'b11);
    tick();
    chk("t3_irq", 32'(o_irq), 32'h1);
    chk("t3_vec", 32'(o_vector), 32'h3F0);
    pulse_ack();
    pulse_reti();

    // 4: event during service accumulates, requested after reti
    intr = 2'b01;
    ticks(4);
    pulse_ack();
    intr = 2'b11;
    ticks(4);
    chk("t4_irq_svc", 32'(o_irq), 32'h0);
    chk("t4_pend_svc", 32'(o_pending_q), 32'h2);
    pulse_reti();
    chk("t4_irq_reti", 32'(o_irq), 32'h0);
    tick();
    chk("t4_irq", 32'(o_irq), 32'h1);
    chk("t4_vec", 32'(o_vector), 32'h3F4);

    // 5: stray reti in REQ, stray ack in IDLE
    pulse_reti();
    chk("t5_irq_hold", 32'(o_irq), 32'h1);
    chk("t5_vec_hold", 32'(o_vector), 32'h3F4);
    pulse_ack();
    pulse_reti();
    pulse_ack();
    chk("t5_irq_idle", 32'(o_irq), 32'h0);
    chk("t5_id_idle", 32'(o_irq_id), 32'h0);

    // 6: reset while requesting, line held high
    intr = 2'b00;
    ticks(3);
    intr = 2'b01;
    ticks(4);
    chk("t6_in_req", 32'(o_irq), 32'h1);
    do_reset();
    ticks(8);
    chk("t6_irq", 32'(o_irq), 32'h0);
    chk("t6_pend", 32'(o_pending_q), 32'h0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(7) == 0) intr[b] = ~intr[b];
      end
      mask_we  = ($urandom_range(15) == 0);
      mask_din = 2'($urandom_range(3));
      ack      = ($urandom_range(3) == 0);
      reti     = ($urandom_range(3) == 0);
      if ($urandom_range(499) == 0) do_reset();
      else tick();
    end
    mask_we = 0; ack = 0; reti = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
